// File: rtl/wconv_fifo.sv
// Width-converting single-clock FIFO: one wide word in, RATIO narrow slices out.
// Optional sticky overflow/underflow flags when WCONV_FIFO_ERR_EN is defined.
module wconv_fifo #(
  parameter int RD_WIDTH   = 16,
  parameter int RATIO      = 4,
  parameter int DEPTH_LOG2 = 7,
  parameter int MSB_FIRST  = 0
) (
  input  logic                         clock_a,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         wr_valid,
  output logic                         wr_ready,
  input  logic [RD_WIDTH*RATIO-1:0]    wr_data,
  output logic                         rd_valid,
  input  logic                         rd_ready,
  output logic [RD_WIDTH-1:0]          rd_data,
  output logic [DEPTH_LOG2:0]          level,
  output logic                         full,
  output logic                         empty
`ifdef WCONV_FIFO_ERR_EN
  ,
  output logic                         err_overflow,
  output logic                         err_underflow
`endif
);

  localparam int WR_WIDTH = RD_WIDTH * RATIO;
  localparam int DEPTH    = 1 << DEPTH_LOG2;
  localparam int LVL_W    = DEPTH_LOG2 + 1;
  localparam int IDX_W    = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

  logic [WR_WIDTH-1:0]   mem [DEPTH];
  logic [WR_WIDTH-1:0]   ram_q_reg;
  logic [WR_WIDTH-1:0]   hold_reg;
  logic                  hold_valid_reg;
  logic [IDX_W-1:0]      idx_reg;
  logic [DEPTH_LOG2-1:0] wr_ptr_reg;
  logic [DEPTH_LOG2-1:0] rd_ptr_reg;
  logic [LVL_W-1:0]      level_reg;
  logic [LVL_W-1:0]      level_next;
  logic [LVL_W-1:0]      avail_reg;
  logic [LVL_W-1:0]      avail_next;
  logic                  wr_d1_reg;
  logic                  full_reg;
  logic                  empty_reg;

  logic clr;
  logic wr_fire;
  logic rd_fire;
  logic last_fire;
  logic load_fire;

  assign clr       = reset | flush;
  assign wr_fire   = wr_valid & ~full_reg & ~clr;
  assign rd_fire   = hold_valid_reg & rd_ready & ~clr;
  assign last_fire = rd_fire & (idx_reg == LAST_IDX);
  // avail_reg only counts words whose RAM read has had a cycle to settle into ram_q_reg.
  assign load_fire = ~clr & (avail_reg != '0) & (~hold_valid_reg | last_fire);

  always_comb begin
    level_next = level_reg + {{(LVL_W-1){1'b0}}, wr_fire} - {{(LVL_W-1){1'b0}}, last_fire};
    avail_next = avail_reg + {{(LVL_W-1){1'b0}}, wr_d1_reg} - {{(LVL_W-1){1'b0}}, load_fire};
  end

  always_ff @(posedge clock_a) begin
    if (wr_fire) begin
      mem[wr_ptr_reg] <= wr_data;
    end
    ram_q_reg <= mem[rd_ptr_reg];
  end

  always_ff @(posedge clock_a) begin
    if (clr) begin
      hold_reg       <= '0;
      hold_valid_reg <= 1'b0;
      idx_reg        <= '0;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      level_reg      <= '0;
      avail_reg      <= '0;
      wr_d1_reg      <= 1'b0;
      full_reg       <= 1'b0;
      empty_reg      <= 1'b1;
    end else begin
      if (wr_fire) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      wr_d1_reg <= wr_fire;
      avail_reg <= avail_next;
      level_reg <= level_next;
      full_reg  <= (level_next == LVL_W'(DEPTH));
      empty_reg <= (level_next == '0);
      if (load_fire) begin
        hold_reg   <= ram_q_reg;
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      if (rd_fire) begin
        idx_reg <= last_fire ? '0 : idx_reg + IDX_W'(1);
      end
      hold_valid_reg <= load_fire | (hold_valid_reg & ~last_fire);
    end
  end

  logic [RD_WIDTH-1:0] slice_arr [RATIO];

  generate
    for (genvar gi = 0; gi < RATIO; gi++) begin : g_slice
      localparam int SRC = (MSB_FIRST != 0) ? (RATIO - 1 - gi) : gi;
      assign slice_arr[gi] = hold_reg[SRC*RD_WIDTH +: RD_WIDTH];
    end
  endgenerate

  assign rd_data  = slice_arr[idx_reg];
  assign rd_valid = hold_valid_reg;
  assign wr_ready = ~full_reg;
  assign full     = full_reg;
  assign empty    = empty_reg;
  assign level    = level_reg;

`ifdef WCONV_FIFO_ERR_EN
  // Sticky across flush; only reset clears them.
  always_ff @(posedge clock_a) begin
    if (reset) begin
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      if (wr_valid & full_reg) begin
        err_overflow <= 1'b1;
      end
      if (rd_ready & ~hold_valid_reg & ~empty_reg) begin
        err_underflow <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_wconv_fifo.sv
// Directed bench for wconv_fifo: default LSB-first instance plus an MSB-first twin
// sharing the same inputs; err flags checked only when WCONV_FIFO_ERR_EN is defined.
module tb_wconv_fifo;

  logic        clock_a = 1'b0;
  logic        reset, flush, wr_valid, rd_ready;
  logic [63:0] wr_data;
  logic        wr_ready, rd_valid, full, empty;
  logic [15:0] rd_data;
  logic [7:0]  level;
  logic        m_wr_ready, m_rd_valid, m_full, m_empty;
  logic [15:0] m_rd_data;
  logic [7:0]  m_level;
`ifdef WCONV_FIFO_ERR_EN
  logic        err_overflow, err_underflow, m_err_overflow, m_err_underflow;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clock_a = ~clock_a;

  wconv_fifo dut (
    .clock_a(clock_a), .reset(reset), .flush(flush),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .level(level), .full(full), .empty(empty)
`ifdef WCONV_FIFO_ERR_EN
    , .err_overflow(err_overflow), .err_underflow(err_underflow)
`endif
  );

  wconv_fifo #(.MSB_FIRST(1)) dut_msb (
    .clock_a(clock_a), .reset(reset), .flush(flush),
    .wr_valid(wr_valid), .wr_ready(m_wr_ready), .wr_data(wr_data),
    .rd_valid(m_rd_valid), .rd_ready(rd_ready), .rd_data(m_rd_data),
    .level(m_level), .full(m_full), .empty(m_empty)
`ifdef WCONV_FIFO_ERR_EN
    , .err_overflow(m_err_overflow), .err_underflow(m_err_underflow)
`endif
  );

  // Slice n of the global stream is 16'h0100 + n; word i carries slices 4i..4i+3.
  function automatic logic [15:0] exp_slice(int n);
    return 16'(n + 'h100);
  endfunction

  function automatic logic [63:0] word_of(int i);
    logic [63:0] w;
    for (int k = 0; k < 4; k++) w[k*16 +: 16] = exp_slice(i*4 + k);
    return w;
  endfunction

  task automatic step();
    @(posedge clock_a);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0; wr_data = '0;
    step(); step();
    reset = 1'b0;
    tests_run++; if (rd_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_rd_valid: got %b expected 0", rd_valid); end
    tests_run++; if (rd_data !== 16'h0) begin tests_failed++; $display("FAIL reset_rd_data: got %h expected 0000", rd_data); end
    tests_run++; if (level !== 8'd0) begin tests_failed++; $display("FAIL reset_level: got %0d expected 0", level); end
    tests_run++; if (empty !== 1'b1) begin tests_failed++; $display("FAIL reset_empty: got %b expected 1", empty); end
    tests_run++; if (full !== 1'b0) begin tests_failed++; $display("FAIL reset_full: got %b expected 0", full); end
    tests_run++; if (wr_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_wr_ready: got %b expected 1", wr_ready); end
`ifdef WCONV_FIFO_ERR_EN
    tests_run++; if (err_overflow !== 1'b0 || err_underflow !== 1'b0) begin tests_failed++; $display("FAIL reset_err: got %b%b expected 00", err_overflow, err_underflow); end
`endif
    $display("[TB] reset applied");
  endtask

  task automatic test_basic();
    logic [15:0] exp_lsb [4];
    exp_lsb[0] = 16'h1111; exp_lsb[1] = 16'h2222; exp_lsb[2] = 16'h3333; exp_lsb[3] = 16'h4444;
    wr_valid = 1'b1; wr_data = 64'h4444_3333_2222_1111; rd_ready = 1'b1;
    step();
    wr_valid = 1'b0;
    $display("[TB] write %h", 64'h4444_3333_2222_1111);
    tests_run++; if (rd_valid !== 1'b0) begin tests_failed++; $display("FAIL basic_lat_e0: got %b expected 0", rd_valid); end
    tests_run++; if (level !== 8'd1) begin tests_failed++; $display("FAIL basic_level1: got %0d expected 1", level); end
    step();
    tests_run++; if (rd_valid !== 1'b0) begin tests_failed++; $display("FAIL basic_lat_e1: got %b expected 0", rd_valid); end
    step();
    for (int k = 0; k < 4; k++) begin
      tests_run++; if (rd_valid !== 1'b1) begin tests_failed++; $display("FAIL basic_valid[%0d]: got %b expected 1", k, rd_valid); end
      tests_run++; if (rd_data !== exp_lsb[k]) begin tests_failed++; $display("FAIL basic_lsb[%0d]: got %h expected %h", k, rd_data, exp_lsb[k]); end
      tests_run++; if (m_rd_data !== exp_lsb[3-k]) begin tests_failed++; $display("FAIL basic_msb[%0d]: got %h expected %h", k, m_rd_data, exp_lsb[3-k]); end
      $display("[TB] read slice %0d lsb=%h msb=%h", k, rd_data, m_rd_data);
      step();
    end
    rd_ready = 1'b0;
    tests_run++; if (rd_valid !== 1'b0) begin tests_failed++; $display("FAIL basic_end_valid: got %b expected 0", rd_valid); end
    tests_run++; if (empty !== 1'b1) begin tests_failed++; $display("FAIL basic_end_empty: got %b expected 1", empty); end
    tests_run++; if (level !== 8'd0) begin tests_failed++; $display("FAIL basic_end_level: got %0d expected 0", level); end
`ifdef WCONV_FIFO_ERR_EN
    tests_run++; if (err_underflow !== 1'b1 || err_overflow !== 1'b0) begin tests_failed++; $display("FAIL basic_err: got ovf=%b unf=%b expected ovf=0 unf=1", err_overflow, err_underflow); end
`endif
  endtask

  task automatic test_fill();
    rd_ready = 1'b0;
    for (int i = 0; i < 128; i++) begin
      wr_valid = 1'b1; wr_data = word_of(i);
      step();
      $display("[TB] fill write %0d data=%h", i, word_of(i));
    end
    wr_valid = 1'b0;
    tests_run++; if (full !== 1'b1) begin tests_failed++; $display("FAIL fill_full: got %b expected 1", full); end
    tests_run++; if (level !== 8'd128) begin tests_failed++; $display("FAIL fill_level: got %0d expected 128", level); end
    tests_run++; if (wr_ready !== 1'b0) begin tests_failed++; $display("FAIL fill_wr_ready: got %b expected 0", wr_ready); end
    tests_run++; if (empty !== 1'b0) begin tests_failed++; $display("FAIL fill_empty: got %b expected 0", empty); end
    wr_valid = 1'b1; wr_data = 64'hDEAD_BEEF_DEAD_BEEF;
    step();
    wr_valid = 1'b0;
    $display("[TB] write 129 offered while full");
    step();
    tests_run++; if (level !== 8'd128) begin tests_failed++; $display("FAIL fill_129_level: got %0d expected 128", level); end
    tests_run++; if (rd_valid !== 1'b1) begin tests_failed++; $display("FAIL fill_hold_valid: got %b expected 1", rd_valid); end
    tests_run++; if (rd_data !== exp_slice(0)) begin tests_failed++; $display("FAIL fill_hold_data: got %h expected %h", rd_data, exp_slice(0)); end
`ifdef WCONV_FIFO_ERR_EN
    tests_run++; if (err_overflow !== 1'b1) begin tests_failed++; $display("FAIL fill_err_overflow: got %b expected 1", err_overflow); end
`endif
  endtask

  task automatic test_drain();
    rd_ready = 1'b1;
    for (int n = 0; n < 512; n++) begin
      tests_run++; if (rd_valid !== 1'b1) begin tests_failed++; $display("FAIL drain_valid[%0d]: got %b expected 1", n, rd_valid); end
      tests_run++; if (rd_data !== exp_slice(n)) begin tests_failed++; $display("FAIL drain_data[%0d]: got %h expected %h", n, rd_data, exp_slice(n)); end
      // Offer a write on the very edge that frees the first slot; it must be refused.
      if (n == 3) begin wr_valid = 1'b1; wr_data = 64'hBAD0_BAD0_BAD0_BAD0; end
      step();
      wr_valid = 1'b0;
      if (n % 4 == 3) $display("[TB] drained word %0d", n / 4);
      if (n == 2) begin
        tests_run++; if (wr_ready !== 1'b0) begin tests_failed++; $display("FAIL drain_wr_ready_early: got %b expected 0", wr_ready); end
      end
      if (n == 3) begin
        tests_run++; if (wr_ready !== 1'b1) begin tests_failed++; $display("FAIL drain_wr_ready_rise: got %b expected 1", wr_ready); end
        tests_run++; if (level !== 8'd127) begin tests_failed++; $display("FAIL drain_boundary_level: got %0d expected 127", level); end
      end
    end
    rd_ready = 1'b0;
    tests_run++; if (rd_valid !== 1'b0) begin tests_failed++; $display("FAIL drain_end_valid: got %b expected 0", rd_valid); end
    tests_run++; if (level !== 8'd0) begin tests_failed++; $display("FAIL drain_end_level: got %0d expected 0", level); end
    tests_run++; if (empty !== 1'b1) begin tests_failed++; $display("FAIL drain_end_empty: got %b expected 1", empty); end
  endtask

  task automatic test_simultaneous();
    rd_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wr_valid = 1'b1; wr_data = word_of(i);
      step();
      $display("[TB] write %0d data=%h", i, word_of(i));
    end
    wr_valid = 1'b0;
    tests_run++; if (level !== 8'd3) begin tests_failed++; $display("FAIL simul_level_pre: got %0d expected 3", level); end
    tests_run++; if (rd_data !== exp_slice(0)) begin tests_failed++; $display("FAIL simul_first: got %h expected %h", rd_data, exp_slice(0)); end
    rd_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      $display("[TB] read slice %0d", k);
    end
    wr_valid = 1'b1; wr_data = word_of(3);
    step();
    wr_valid = 1'b0; rd_ready = 1'b0;
    $display("[TB] last slice read with concurrent write");
    tests_run++; if (level !== 8'd3) begin tests_failed++; $display("FAIL simul_level: got %0d expected 3", level); end
    tests_run++; if (rd_valid !== 1'b1) begin tests_failed++; $display("FAIL simul_valid: got %b expected 1", rd_valid); end
    tests_run++; if (rd_data !== exp_slice(4)) begin tests_failed++; $display("FAIL simul_next: got %h expected %h", rd_data, exp_slice(4)); end
  endtask

  task automatic test_flush();
    rd_ready = 1'b1;
    step(); step();
    rd_ready = 1'b0;
    tests_run++; if (rd_data !== exp_slice(6)) begin tests_failed++; $display("FAIL flush_pre_slice: got %h expected %h", rd_data, exp_slice(6)); end
    flush = 1'b1; wr_valid = 1'b1; wr_data = word_of(9); rd_ready = 1'b1;
    step();
    flush = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0;
    $display("[TB] flush with concurrent write");
    tests_run++; if (level !== 8'd0) begin tests_failed++; $display("FAIL flush_level: got %0d expected 0", level); end
    tests_run++; if (rd_valid !== 1'b0) begin tests_failed++; $display("FAIL flush_valid: got %b expected 0", rd_valid); end
    tests_run++; if (empty !== 1'b1 || full !== 1'b0) begin tests_failed++; $display("FAIL flush_flags: got empty=%b full=%b expected 1 0", empty, full); end
    step(); step(); step();
    tests_run++; if (rd_valid !== 1'b0 || level !== 8'd0) begin tests_failed++; $display("FAIL flush_write_dropped: got valid=%b level=%0d expected 0 0", rd_valid, level); end
`ifdef WCONV_FIFO_ERR_EN
    tests_run++; if (err_overflow !== 1'b1 || err_underflow !== 1'b1) begin tests_failed++; $display("FAIL flush_err_kept: got %b%b expected 11", err_overflow, err_underflow); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    tests_run++; if (err_overflow !== 1'b0 || err_underflow !== 1'b0) begin tests_failed++; $display("FAIL reset_err_clear: got %b%b expected 00", err_overflow, err_underflow); end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_fill();
    test_drain();
    test_simultaneous();
    test_flush();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
